// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared VDP geometry constants, fetch slot encodings and address helper
package vdp_pkg;
  localparam int ACTIVE_W  = 256;
  localparam int ACTIVE_H  = 192;
  localparam int TILE_COLS = 32;
  localparam int TILE_ROWS = 24;

  localparam logic [2:0] SLOT_NAME = 3'd0;
  localparam logic [2:0] SLOT_PAT  = 3'd1;
  localparam logic [2:0] SLOT_COL  = 3'd2;
  localparam logic [2:0] SLOT_LOAD = 3'd7;

  // row[7:3]*TILE_COLS + col, with TILE_COLS a power of two so it is a concatenation
  function automatic logic [15:0] nameOffset(input logic [7:0] row, input logic [4:0] col);
    return {6'd0, row[7:3], col};
  endfunction
endpackage

// File: rtl/tile_shifter.sv
// rtl/tile_shifter.sv - 8-bit pattern shift register plus fg/bg colour register
module tile_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] patternIn,
  input  logic [7:0] colourIn,
  output logic [3:0] pixel
);
  logic [7:0] shiftReg;
  logic [7:0] colourReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shiftReg  <= '0;
      colourReg <= '0;
    end else if (load) begin
      shiftReg  <= patternIn;
      colourReg <= colourIn;
    end else if (shift) begin
      shiftReg <= {shiftReg[6:0], 1'b0};
    end
  end

  assign pixel = shiftReg[7] ? colourReg[7:4] : colourReg[3:0];
endmodule

// File: rtl/tile_renderer.sv
// rtl/tile_renderer.sv - tile-mode pixel generator with fixed 8-slot VRAM fetch schedule
module tile_renderer
  import vdp_pkg::*;
#(
  parameter logic [15:0] NAME_BASE = 16'h0000,
  parameter logic [15:0] PAT_BASE  = 16'h0800,
  parameter logic [15:0] COL_BASE  = 16'h2000,
  parameter int          H_TOTAL   = 336,
  parameter logic [3:0]  BORDER    = 4'b0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  xPos,
  input  logic [8:0]  yPos,
  input  logic        isActive,
  output logic [15:0] vAddress,
  input  logic [7:0]  vDataRead,
  output logic        vramGrant,
  output logic [3:0]  rgb
);
  localparam logic [8:0] FETCH_END  = 9'(ACTIVE_W - 8);
  localparam logic [8:0] PREFETCH_X = 9'(H_TOTAL - 8);
  localparam logic [8:0] LAST_X     = 9'(H_TOTAL - 1);
  localparam logic [8:0] LINES      = 9'(ACTIVE_H);

  logic [2:0]  slot;
  logic [8:0]  yNext;
  logic        inLineFetch, inPrefetch, fetchNow, inArea;
  logic [4:0]  col;
  logic [7:0]  row;
  logic [15:0] addrNext;
  logic [7:0]  nameLatch, patLatch, colLatch;
  logic [8:0]  xn, yn, ynNext;
  logic        ownNext;
  logic [3:0]  pixel;

  assign slot        = xPos[2:0];
  assign yNext       = yPos + 9'd1;
  assign inLineFetch = (xPos < FETCH_END) && (yPos < LINES);
  assign inPrefetch  = (xPos >= PREFETCH_X) && (yNext < LINES);
  assign fetchNow    = inLineFetch || inPrefetch;
  assign inArea      = !xPos[8] && (yPos < LINES);

  always_comb begin
    col = 5'd0;
    row = yNext[7:0];
    if (inLineFetch) begin
      col = xPos[7:3] + 5'd1;
      row = yPos[7:0];
    end
  end

  // The pattern address uses the name byte arriving this cycle, not the latch
  always_comb begin
    addrNext = '0;
    if (fetchNow) begin
      case (slot)
        SLOT_NAME: addrNext = NAME_BASE + nameOffset(row, col);
        SLOT_PAT:  addrNext = PAT_BASE + {5'd0, vDataRead, 3'd0} + {13'd0, row[2:0]};
        SLOT_COL:  addrNext = COL_BASE + {5'd0, nameLatch, 3'd0} + {13'd0, row[2:0]};
        default:   addrNext = '0;
      endcase
    end
  end

  assign vAddress = reset ? 16'd0 : addrNext;

  // Grant looks one cycle ahead; at the line wrap the next line number is yPos+1
  assign xn      = (xPos == LAST_X) ? 9'd0 : xPos + 9'd1;
  assign yn      = (xPos == LAST_X) ? yNext : yPos;
  assign ynNext  = yn + 9'd1;
  assign ownNext = (((xn < FETCH_END) && (yn < LINES)) || ((xn >= PREFETCH_X) && (ynNext < LINES)))
                   && (xn[2:0] <= SLOT_COL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nameLatch <= '0;
      patLatch  <= '0;
      colLatch  <= '0;
      rgb       <= '0;
      vramGrant <= 1'b1;
    end else begin
      if (fetchNow && slot == SLOT_PAT)         nameLatch <= vDataRead;
      if (fetchNow && slot == SLOT_COL)         patLatch  <= vDataRead;
      if (fetchNow && slot == SLOT_COL + 3'd1)  colLatch  <= vDataRead;
      vramGrant <= !ownNext;
      if (!isActive)    rgb <= 4'd0;
      else if (!inArea) rgb <= BORDER;
      else              rgb <= pixel;
    end
  end

  tile_shifter shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (fetchNow && slot == SLOT_LOAD),
    .shift    (inArea && slot != SLOT_LOAD),
    .patternIn(patLatch),
    .colourIn (colLatch),
    .pixel    (pixel)
  );
endmodule
